fetch_ctrl: RTL



---
 rtl/fetch_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with single skid entry and redirect handling
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic        valid_F,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state, next_state;
    logic [31:0] pc;
    logic [31:0] old_addr;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic ack;
    logic consume;
    logic slot_free;
    logic take_out;
    logic take_skid;
    logic skid_pop;
    logic pc_inc;

    assign consume   = valid_F & ~stall_D;
    assign slot_free = ~valid_F | consume;
    assign ack       = imem_ack & imem_req;

    // DISCARD keeps presenting the abandoned address until its ack drains
    assign imem_req  = ~reset & ((state == REQ) | (state == DISCARD));
    assign imem_addr = (state == DISCARD) ? old_addr : pc;

    always_comb begin
        next_state = state;
        take_out   = 1'b0;
        take_skid  = 1'b0;
        skid_pop   = 1'b0;
        pc_inc     = 1'b0;
        case (state)
            IDLE: next_state = REQ;
            REQ: begin
                if (redirect) begin
                    next_state = ack ? REQ : DISCARD;
                end else if (ack) begin
                    pc_inc = 1'b1;
                    if (slot_free) begin
                        take_out = 1'b1;
                    end else begin
                        take_skid  = 1'b1;
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    next_state = REQ;
                end else if (consume) begin
                    skid_pop   = 1'b1;
                    next_state = REQ;
                end
            end
            DISCARD: begin
                if (ack) next_state = REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC & ~32'd3;
            old_addr   <= 32'd0;
            skid_instr <= 32'd0;
            skid_pc    <= 32'd0;
            Instr_F    <= 32'd0;
            PC_F       <= 32'd0;
            valid_F    <= 1'b0;
            fetch_cnt  <= 32'd0;
        end else begin
            state <= next_state;
            if (consume) fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect) begin
                pc      <= redirect_pc & ~32'd3;
                valid_F <= 1'b0;
                if (state == REQ && !ack) old_addr <= pc;
            end else begin
                if (pc_inc) pc <= pc + 32'd4;
                if (take_out) begin
                    Instr_F <= imem_rdata;
                    PC_F    <= pc;
                    valid_F <= 1'b1;
                end else if (skid_pop) begin
                    Instr_F <= skid_instr;
                    PC_F    <= skid_pc;
                    valid_F <= 1'b1;
                end else if (consume) begin
                    valid_F <= 1'b0;
                end
                if (take_skid) begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= pc;
                end
            end
        end
    end

endmodule
